// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator, WIDTH iterations.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  // Upper half: partial product / remainder. Lower half: multiplier / dividend->quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   dividendRaw;
  logic               isDiv;
  logic               signA;
  logic               signB;
  logic               divZero;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     remShift;
  logic               remGe;
  logic [WIDTH-1:0]   remSub;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  // Signed ops (op[0]=1) work on magnitudes; signs are reapplied in FIX.
  always_comb begin
    absA = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
    absB = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // One iteration of either algorithm.
  always_comb begin
    addSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remGe    = (remShift >= {1'b0, operand});
    remSub   = remShift[WIDTH-1:0] - operand;
    if (isDiv) begin
      accNext = {(remGe ? remSub : remShift[WIDTH-1:0]), acc[WIDTH-2:0], remGe};
    end else begin
      accNext = {addSum, acc[WIDTH-1:1]};
    end
  end

  // Sign fixup and divide-by-zero override applied at the FIX edge.
  always_comb begin
    product = (signA ^ signB) ? (~acc + 1'b1) : acc;
    resHi   = product[2*WIDTH-1:WIDTH];
    resLo   = product[WIDTH-1:0];
    if (isDiv) begin
      if (divZero) begin
        resHi = dividendRaw;
        resLo = {WIDTH{1'b1}};
      end else begin
        resLo = (signA ^ signB) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        resHi = signA ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Control and architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            if (mt_hi) hi <= mt_data;
            if (mt_lo) lo <= mt_data;
          end
        end
        RUN: begin
          if (count == LAST_ITER) state <= FIX;
        end
        FIX: begin
          hi    <= resHi;
          lo    <= resLo;
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded at start
  // before being read, and reset already prevents a stale result reaching HI/LO.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      acc         <= {{WIDTH{1'b0}}, absA};
      operand     <= absB;
      dividendRaw <= a;
      isDiv       <= op[1];
      signA       <= op[0] & a[WIDTH-1];
      signB       <= op[0] & b[WIDTH-1];
      divZero     <= (b == '0);
      count       <= '0;
    end else if (state == RUN) begin
      acc   <= accNext;
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Inputs are driven and outputs sampled on the falling edge.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LATENCY = W + 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mt_hi;
  logic         mt_lo;
  logic [W-1:0] mt_data;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  int lat;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge. Issues one op, then waits (bounded) for done;
  // returns just after the falling edge where done is high. lat counts edges from
  // the accepting edge E0 through the edge that raises done.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(LATENCY));
    check({tag, "_busyLow"}, 64'(busy), 64'd0);
  endtask

  task automatic expectResult(input string tag, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    check({tag, "_hi"}, 64'(hi), 64'(expHi));
    check({tag, "_lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    expectResult("rst", 32'h0, 32'h0);

    // Multiply; the second call starts in the cycle done is high (no bubble).
    runOp("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expectResult("multu_max", 32'hFFFFFFFE, 32'h00000001);
    runOp("mult_neg", 2'b01, 32'hFFFFFFFD, 32'h00000005);
    expectResult("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    runOp("mult_min", 2'b01, 32'h80000000, 32'h80000000);
    expectResult("mult_min", 32'h40000000, 32'h00000000);

    // Divide, including signed cases and the MIN_INT / -1 overflow.
    runOp("div_neg", 2'b11, 32'hFFFFFFF9, 32'h00000002);
    expectResult("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_negDivisor", 2'b11, 32'h00000007, 32'hFFFFFFFE);
    expectResult("div_negDivisor", 32'h00000001, 32'hFFFFFFFD);
    runOp("divu", 2'b10, 32'h00000007, 32'h00000002);
    expectResult("divu", 32'h00000001, 32'h00000003);
    runOp("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF);
    expectResult("div_ovf", 32'h00000000, 32'h80000000);

    // Divide by zero: raw dividend in HI, all ones in LO, full latency.
    runOp("divu_zero", 2'b10, 32'h00000007, 32'h00000000);
    expectResult("divu_zero", 32'h00000007, 32'hFFFFFFFF);
    runOp("div_zero", 2'b11, 32'hFFFFFFF9, 32'h00000000);
    expectResult("div_zero", 32'hFFFFFFF9, 32'hFFFFFFFF);

    // start and mt_lo while busy are ignored; HI/LO hold until FIX.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd5; mt_lo = 1'b1; mt_data = 32'h77;
    @(negedge clk);
    lat++;
    start = 1'b0; mt_lo = 1'b0;
    expectResult("hold_old", 32'hFFFFFFF9, 32'hFFFFFFFF);
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("ignore_lat", 64'(lat), 64'(LATENCY));
    expectResult("ignore", 32'h0, 32'h0000000C);
    @(negedge clk);
    mt_hi = 1'b1; mt_data = 32'h1234;
    @(negedge clk);
    mt_hi = 1'b0;
    expectResult("mthi", 32'h00001234, 32'h0000000C);

    // start wins over a simultaneous mt write in IDLE.
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd5; mt_hi = 1'b1; mt_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mt_hi = 1'b0;
    check("startWins_hi", 64'(hi), 64'h1234);
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    expectResult("startWins", 32'h0, 32'h0000000A);

    // Reset mid-run discards the operation.
    @(negedge clk);
    mt_lo = 1'b1; mt_data = 32'h55;
    @(negedge clk);
    mt_lo = 1'b0;
    check("mtlo", 64'(lo), 64'h55);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midRst_busy", 64'(busy), 64'd0);
    check("midRst_done", 64'(done), 64'd0);
    expectResult("midRst", 32'h0, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("noLateDone", 64'(seen), 64'd0);
    runOp("afterRst", 2'b10, 32'd100, 32'd7);
    expectResult("afterRst", 32'd2, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
